// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and default addresses for the OAM sprite-DMA arbiter.
package oam_dma_arbiter_pkg;

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

  localparam logic [15:0] DMA_REG_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_DEFAULT = 16'h2004;
  localparam int unsigned IDX_N            = 9;

endpackage

// File: rtl/oam_dma_arbiter_latch.sv
// Byte-wide holding register with write enable and synchronous active-low reset.
module oam_dma_arbiter_latch #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/oam_dma_arbiter.sv
// CPU bus pass-through with a 256-byte sprite DMA that stalls the CPU while copying to OAM.
// Optional macro OAM_DMA_ALIGN_EN inserts an ALIGN cycle when the HALT cycle has odd parity.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_N   = 16,
  parameter int unsigned       DATA_N   = 8,
  parameter logic [ADDR_N-1:0] DMA_REG  = ADDR_N'(DMA_REG_DEFAULT),
  parameter logic [ADDR_N-1:0] OAM_DATA = ADDR_N'(OAM_DATA_DEFAULT),
  parameter int unsigned       DMA_LEN  = 256
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cpu_we,
  input  logic              cpu_oe,
  input  logic [ADDR_N-1:0] cpu_addr,
  input  logic [DATA_N-1:0] cpu_wdata,
  output logic              cpu_rdy,
  output logic              busy,
  output logic              bus_we,
  output logic              bus_oe,
  output logic [ADDR_N-1:0] bus_addr,
  inout  wire  [DATA_N-1:0] bus_data
);

  localparam logic [IDX_N-1:0] LastIdx = IDX_N'(DMA_LEN - 1);

  dma_state_t        state_q, state_d;
  logic [IDX_N-1:0]  idx_q, idx_d;
  logic [DATA_N-1:0] page_q, page_d;
  logic [DATA_N-1:0] latch_q;
  logic              cyc_q;
  logic              latch_we;
  logic              drv_en;
  logic [DATA_N-1:0] drv_val;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      page_q  <= '0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      cyc_q   <= ~cyc_q;
    end
  end

  oam_dma_arbiter_latch #(
    .Width (DATA_N)
  ) u_latch (
    .clk_i  (clk),
    .rst_ni (n_reset),
    .we_i   (latch_we),
    .d_i    (bus_data),
    .q_o    (latch_q)
  );

  assign bus_data = drv_en ? drv_val : {DATA_N{1'bz}};

`ifndef OAM_DMA_ALIGN_EN
  // Parity only matters when alignment is compiled in.
  logic unused_cyc;
  assign unused_cyc = cyc_q;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    page_d   = page_q;
    cpu_rdy  = 1'b0;
    busy     = 1'b1;
    bus_we   = 1'b0;
    bus_oe   = 1'b0;
    bus_addr = '0;
    drv_en   = 1'b0;
    drv_val  = '0;
    latch_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_rdy  = 1'b1;
        busy     = 1'b0;
        bus_we   = cpu_we;
        bus_oe   = cpu_oe;
        bus_addr = cpu_addr;
        drv_en   = cpu_we;
        drv_val  = cpu_wdata;
        // The trigger write itself still reaches the bus this cycle.
        if (cpu_we && (cpu_addr == DMA_REG)) begin
          page_d  = cpu_wdata;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_d = cyc_q ? ALIGN : READ;
`else
        state_d = READ;
`endif
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        bus_oe   = 1'b1;
        bus_addr = ADDR_N'({page_q, idx_q[7:0]});
        latch_we = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        bus_we   = 1'b1;
        bus_addr = OAM_DATA;
        drv_en   = 1'b1;
        drv_val  = latch_q;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: table vectors, random idle traffic, DMA scoreboard.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        cpu_we, cpu_oe;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy, busy, bus_we, bus_oe;
  logic [15:0] bus_addr;
  wire  [7:0]  bus_data;

  logic [7:0]  mem [0:65535];
  logic        par;
  int          checks = 0;
  int          failures = 0;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  always #5 clk = ~clk;

  // Memory model answers system reads.
  assign bus_data = (bus_oe && !bus_we) ? mem[bus_addr] : 8'hzz;

  // Expected parity of the current cycle: zero after reset, toggling each clock.
  always @(posedge clk) par <= n_reset ? ~par : 1'b0;

  oam_dma_arbiter dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cpu_we    (cpu_we),
    .cpu_oe    (cpu_oe),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdy   (cpu_rdy),
    .busy      (busy),
    .bus_we    (bus_we),
    .bus_oe    (bus_oe),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic        oe;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_we;
    logic        exp_oe;
    logic [15:0] exp_addr;
    logic        chk_data;
    logic [7:0]  exp_data;
  } vec_t;

  // Starts and ends at posedge+1. Triggers a DMA of the given page and scores the transfer.
  task automatic run_dma(input logic [7:0] page);
    int          stall;
    int          busy_err;
    int          order_err;
    int          waddr_err;
    bit          done;
    logic        halt_par;
    int          exp_stall;
    logic [15:0] ev_addr[$];
    logic [7:0]  ev_data[$];
    bit          ev_wr[$];
    int          ev_cyc[$];
    cpu_we = 1'b1; cpu_oe = 1'b0; cpu_addr = 16'h4014; cpu_wdata = page;
    @(negedge clk);
    check("trigger_bus_we", {31'd0, bus_we}, 32'd1);
    check("trigger_bus_data", {24'd0, bus_data}, {24'd0, page});
    check("trigger_rdy", {31'd0, cpu_rdy}, 32'd1);
    halt_par  = ~par;
    exp_stall = 513 + ((AlignEn && halt_par) ? 1 : 0);
    stall = 0; busy_err = 0; done = 1'b0;
    for (int n = 0; n < 700 && !done; n++) begin
      @(posedge clk); #1;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_oe    = !cpu_we && ($urandom_range(0, 1) == 1);
      cpu_addr  = (stall < 400 && $urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
      if (cpu_addr == 16'h4014 && stall >= 400) cpu_addr = 16'h0000;
      cpu_wdata = 8'($urandom);
      @(negedge clk);
      if (cpu_rdy) begin
        done = 1'b1;
      end else begin
        stall++;
        if (!busy) busy_err++;
        if (bus_oe || bus_we) begin
          ev_wr.push_back(bus_we);
          ev_addr.push_back(bus_addr);
          ev_data.push_back(bus_data);
          ev_cyc.push_back(stall);
        end
      end
    end
    check("dma_completed", {31'd0, done}, 32'd1);
    check("stall_cycles", stall, exp_stall);
    check("busy_during_stall", busy_err, 0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("event_count", ev_wr.size(), 512);
    order_err = 0; waddr_err = 0;
    for (int i = 0; i < 256 && ev_wr.size() >= 512; i++) begin
      if (ev_wr[2*i] != 1'b0 || ev_wr[2*i+1] != 1'b1) order_err++;
      if (ev_cyc[2*i+1] != ev_cyc[2*i] + 1) order_err++;
      if (ev_addr[2*i+1] != 16'h2004) waddr_err++;
      check("read_addr", {16'd0, ev_addr[2*i]}, {16'd0, page, 8'(i)});
      check("oam_data", {24'd0, ev_data[2*i+1]}, {24'd0, mem[{page, 8'(i)}]});
    end
    check("read_write_order", order_err, 0);
    check("write_addr", waddr_err, 0);
    if (ev_addr.size() >= 511)
      check("last_read_addr", {16'd0, ev_addr[510]}, {16'd0, page, 8'hFF});
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_oe = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic align_parity(input logic want);
    for (int n = 0; n < 4 && ((~par) != want); n++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   writes;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
    mem[16'h4014] = 8'h77;

    vecs[0] = '{1'b1, 1'b0, 16'h0200, 8'h5A, 1'b1, 1'b0, 16'h0200, 1'b1, 8'h5A};
    vecs[1] = '{1'b0, 1'b1, 16'h4014, 8'h00, 1'b0, 1'b1, 16'h4014, 1'b1, 8'h77};
    vecs[2] = '{1'b1, 1'b0, 16'h4015, 8'hC3, 1'b1, 1'b0, 16'h4015, 1'b1, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 16'h0300, 8'h00, 1'b0, 1'b1, 16'h0300, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 16'h1234, 8'h99, 1'b0, 1'b0, 16'h1234, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 16'h2004, 8'h11, 1'b1, 1'b0, 16'h2004, 1'b1, 8'h11};

    n_reset = 1'b0; cpu_we = 1'b0; cpu_oe = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_rdy", {31'd0, cpu_rdy}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b1;

    for (int k = 0; k < 6; k++) begin
      cpu_we = vecs[k].we; cpu_oe = vecs[k].oe;
      cpu_addr = vecs[k].addr; cpu_wdata = vecs[k].wdata;
      @(negedge clk);
      check("vec_bus_we", {31'd0, bus_we}, {31'd0, vecs[k].exp_we});
      check("vec_bus_oe", {31'd0, bus_oe}, {31'd0, vecs[k].exp_oe});
      check("vec_bus_addr", {16'd0, bus_addr}, {16'd0, vecs[k].exp_addr});
      if (vecs[k].chk_data) check("vec_bus_data", {24'd0, bus_data}, {24'd0, vecs[k].exp_data});
      check("vec_rdy", {31'd0, cpu_rdy}, 32'd1);
      check("vec_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    cpu_we = 1'b0; cpu_oe = 1'b0;
    @(negedge clk);
    check("no_trigger_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Random idle traffic: the bus must mirror the CPU exactly.
    for (int k = 0; k < 40; k++) begin
      cpu_we = 1'($urandom_range(0, 1));
      cpu_oe = !cpu_we && ($urandom_range(0, 1) == 1);
      cpu_addr = 16'($urandom);
      if (cpu_we && cpu_addr == 16'h4014) cpu_addr = 16'h4015;
      cpu_wdata = 8'($urandom);
      @(negedge clk);
      check("rnd_bus_we", {31'd0, bus_we}, {31'd0, cpu_we});
      check("rnd_bus_oe", {31'd0, bus_oe}, {31'd0, cpu_oe});
      check("rnd_bus_addr", {16'd0, bus_addr}, {16'd0, cpu_addr});
      if (cpu_we) check("rnd_wdata", {24'd0, bus_data}, {24'd0, cpu_wdata});
      if (cpu_oe) check("rnd_rdata", {24'd0, bus_data}, {24'd0, mem[cpu_addr]});
      check("rnd_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    cpu_we = 1'b0; cpu_oe = 1'b0;

    align_parity(1'b0);
    run_dma(8'h03);
    align_parity(1'b1);
    run_dma(8'h03);
    run_dma(8'hFF);

    cpu_we = 1'b1; cpu_addr = 16'h0201; cpu_wdata = 8'h3C;
    @(negedge clk);
    check("post_ff_bus_addr", {16'd0, bus_addr}, 32'h0201);
    check("post_ff_rdy", {31'd0, cpu_rdy}, 32'd1);
    @(posedge clk); #1;

    // Abort mid-transfer with reset, then restart.
    cpu_we = 1'b1; cpu_oe = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h03;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    writes = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (bus_we && !cpu_rdy) writes++;
      if (writes == 100) break;
      @(posedge clk); #1;
    end
    check("abort_reached", writes, 100);
    @(posedge clk); #1;
    n_reset = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h66;
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    check("abort_rdy", {31'd0, cpu_rdy}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bus_we", {31'd0, bus_we}, 32'd1);
    check("abort_bus_addr", {16'd0, bus_addr}, 32'h0200);
    check("abort_bus_data", {24'd0, bus_data}, 32'h66);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    run_dma(8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
